// File: rtl/conv3x3_feeder.sv
// conv3x3_feeder: buffers one 9-pixel window and issues it tap by tap as registered x/w/psum triples
module conv3x3_feeder #(
  parameter int X_BW   = 8,
  parameter int W_BW   = 8,
  parameter int I_BW   = 19,
  parameter int TAPS   = 9,
  parameter int CNT_BW = 16
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_en,
  input  logic              i_w_wr,
  input  logic [3:0]        i_w_addr,
  input  logic [I_BW-1:0]   i_w_data,
  input  logic              i_x_valid,
  input  logic [X_BW-1:0]   i_x,
  output logic              o_x_ready,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [X_BW-1:0]   o_x,
  output logic [W_BW-1:0]   o_w,
  output logic [I_BW-1:0]   o_psum,
  output logic              o_first,
  output logic              o_last,
  output logic              o_busy,
  output logic [CNT_BW-1:0] o_win_cnt
);
  typedef enum logic [1:0] {IDLE, FILL, ISSUE} state_t;
  localparam logic [3:0] LAST = 4'(TAPS - 1);
  localparam logic [3:0] BIAS = 4'(TAPS);
  state_t            state_q, state_d;
  logic [3:0]        fill_q, fill_d, tap_q, tap_d;
  logic [X_BW-1:0]   pix_q [TAPS];
  logic [W_BW-1:0]   wbank_q [TAPS];
  logic [I_BW-1:0]   bias_q;
  logic [CNT_BW-1:0] win_cnt_q;
  logic              x_ready_q, valid_q, first_q, last_q, busy_q;
  logic [X_BW-1:0]   x_q;
  logic [W_BW-1:0]   w_q;
  logic [I_BW-1:0]   psum_q;
  logic              x_acc, t_acc, win_done, issue_d;
  assign x_acc    = x_ready_q && i_x_valid;
  assign t_acc    = valid_q && i_ready;
  assign win_done = t_acc && tap_q == LAST;
  assign issue_d  = state_d == ISSUE;
  always_comb begin
    state_d = state_q;
    fill_d  = fill_q;
    tap_d   = tap_q;
    if (state_q == IDLE && i_en) state_d = FILL;
    if (x_acc) begin
      fill_d = (fill_q == LAST) ? '0 : fill_q + 4'd1;
      if (fill_q == LAST) state_d = ISSUE;
    end
    if (t_acc) begin
      tap_d = win_done ? '0 : tap_q + 4'd1;
      if (win_done) state_d = i_en ? FILL : IDLE;
    end
  end
  // Issue outputs are computed from the next tap so they are registered yet appear on the entry edge.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q   <= IDLE;
      fill_q    <= '0;
      tap_q     <= '0;
      bias_q    <= '0;
      win_cnt_q <= '0;
      x_ready_q <= 1'b0;
      valid_q   <= 1'b0;
      first_q   <= 1'b0;
      last_q    <= 1'b0;
      busy_q    <= 1'b0;
      x_q       <= '0;
      w_q       <= '0;
      psum_q    <= '0;
      for (int i = 0; i < TAPS; i++) begin
        pix_q[i]   <= '0;
        wbank_q[i] <= '0;
      end
    end else begin
      state_q   <= state_d;
      fill_q    <= fill_d;
      tap_q     <= tap_d;
      if (state_q == IDLE && i_w_wr && i_w_addr < BIAS) wbank_q[i_w_addr] <= i_w_data[W_BW-1:0];
      if (state_q == IDLE && i_w_wr && i_w_addr == BIAS) bias_q <= i_w_data;
      if (x_acc) pix_q[fill_q] <= i_x;
      if (win_done) win_cnt_q <= win_cnt_q + 1'b1;
      x_ready_q <= state_d == FILL;
      busy_q    <= state_d != IDLE;
      valid_q   <= issue_d;
      x_q       <= issue_d ? pix_q[tap_d] : '0;
      w_q       <= issue_d ? wbank_q[tap_d] : '0;
      psum_q    <= (issue_d && tap_d == '0) ? bias_q : '0;
      first_q   <= issue_d && tap_d == '0;
      last_q    <= issue_d && tap_d == LAST;
    end
  end
  assign o_x_ready = x_ready_q;
  assign o_valid   = valid_q;
  assign o_x       = x_q;
  assign o_w       = w_q;
  assign o_psum    = psum_q;
  assign o_first   = first_q;
  assign o_last    = last_q;
  assign o_busy    = busy_q;
  assign o_win_cnt = win_cnt_q;
endmodule

// File: tb/tb_conv3x3_feeder.sv
// tb_conv3x3_feeder: directed tables, corner sequences and a scoreboarded random run for conv3x3_feeder
module tb_conv3x3_feeder;
  logic        i_clk = 0, i_rst = 0, i_en = 0, i_w_wr = 0, i_x_valid = 0, i_ready = 1;
  logic [3:0]  i_w_addr = 0;
  logic [18:0] i_w_data = 0;
  logic [7:0]  i_x = 0;
  logic        o_x_ready, o_valid, o_first, o_last, o_busy;
  logic [7:0]  o_x, o_w;
  logic [18:0] o_psum;
  logic [15:0] o_win_cnt;
  conv3x3_feeder dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_en(i_en), .i_w_wr(i_w_wr), .i_w_addr(i_w_addr),
    .i_w_data(i_w_data), .i_x_valid(i_x_valid), .i_x(i_x), .o_x_ready(o_x_ready),
    .o_valid(o_valid), .i_ready(i_ready), .o_x(o_x), .o_w(o_w), .o_psum(o_psum),
    .o_first(o_first), .o_last(o_last), .o_busy(o_busy), .o_win_cnt(o_win_cnt)
  );
  always #5 i_clk = ~i_clk;
  typedef struct {logic [7:0] x; logic [7:0] w; logic [18:0] p; logic f; logic l;} vec_t;
  vec_t        tv [9];
  int          checks = 0, errors = 0, exp_win = 0;
  logic [7:0]  cur_px [9];
  logic [7:0]  ew [9];
  logic [18:0] eb;
  logic [7:0]  m_w [9];
  logic [18:0] m_b;
  logic [7:0]  pend [$];
  logic [36:0] sb [$];
  logic [37:0] pout;
  logic        pv = 0, pr = 0;
  int          popped = 0;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask
  task automatic cyc;
    @(negedge i_clk);
  endtask
  task automatic wr(input logic [3:0] a, input logic [18:0] d);
    i_w_wr = 1; i_w_addr = a; i_w_data = d;
    cyc;
    i_w_wr = 0;
  endtask
  task automatic fill;
    i_x_valid = 1;
    for (int k = 0; k < 9; k++) begin
      chk("fill_ready", {o_x_ready, o_valid}, 2'b10);
      i_x = cur_px[k];
      cyc;
    end
    i_x_valid = 0;
  endtask
  task automatic issue_chk(input string nm);
    i_ready = 1;
    for (int k = 0; k < 9; k++) begin
      chk(nm, {o_valid, o_x_ready, o_x, o_w, o_psum, o_first, o_last},
          {1'b1, 1'b0, cur_px[k], ew[k], (k == 0) ? eb : 19'd0, 1'(k == 0), 1'(k == 8)});
      cyc;
    end
    chk({nm, "_after"}, {o_valid, o_x, o_w, o_psum, o_first, o_last}, '0);
  endtask
  task automatic start_window;
    i_en = 1;
    cyc;
    i_en = 0;
    chk("start_busy", {o_busy, o_x_ready}, 2'b11);
  endtask
  task automatic rstep;
    i_x_valid = $urandom_range(3) != 0;
    i_x = 8'($urandom);
    i_ready = $urandom_range(2) != 0;
    chk("rand_excl", o_x_ready & o_valid, 0);
    if (pv && !pr) chk("rand_stall", {o_valid, o_x, o_w, o_psum, o_first, o_last}, pout);
    if (i_x_valid && o_x_ready) begin
      pend.push_back(i_x);
      if (pend.size() == 9) begin
        for (int k = 0; k < 9; k++)
          sb.push_back({pend[k], m_w[k], (k == 0) ? m_b : 19'd0, 1'(k == 0), 1'(k == 8)});
        pend.delete();
      end
    end
    if (o_valid && i_ready) begin
      if (sb.size() == 0) chk("rand_unexpected", 1, 0);
      else begin
        chk("rand_triple", {o_x, o_w, o_psum, o_first, o_last}, sb.pop_front());
        popped++;
      end
    end
    pv = o_valid; pr = i_ready;
    pout = {o_valid, o_x, o_w, o_psum, o_first, o_last};
    cyc;
  endtask
  initial begin
    int firsts [$];
    int lasts, c, n;
    for (int k = 0; k < 9; k++)
      tv[k] = '{x: 8'(k + 1), w: 8'(k + 1), p: (k == 0) ? 19'd100 : 19'd0, f: k == 0, l: k == 8};
    // reset asserted between edges must clear outputs immediately
    #3 i_rst = 1;
    #1 chk("reset_outs", {o_x_ready, o_valid, o_x, o_w, o_psum, o_first, o_last, o_busy, o_win_cnt}, '0);
    cyc;
    i_rst = 0;
    repeat (3) cyc;
    chk("idle_hold", {o_busy, o_x_ready, o_valid}, '0);
    // basic window from the table
    for (int k = 0; k < 9; k++) wr(4'(k), {11'd0, tv[k].w});
    wr(9, 19'd100);
    for (int k = 0; k < 9; k++) cur_px[k] = tv[k].x;
    start_window;
    fill;
    for (int k = 0; k < 9; k++) begin
      chk("basic_tap", {o_valid, o_x_ready, o_x, o_w, o_psum, o_first, o_last},
          {1'b1, 1'b0, tv[k].x, tv[k].w, tv[k].p, tv[k].f, tv[k].l});
      cyc;
    end
    exp_win++;
    chk("basic_done", {o_busy, o_valid, 16'(o_win_cnt)}, {2'b00, 16'(exp_win)});
    for (int k = 0; k < 9; k++) ew[k] = 8'(k + 1);
    eb = 19'd100;
    // backpressure at tap 4 for 3 cycles
    start_window;
    fill;
    for (c = 0; c < 12; c++) begin
      i_ready = !(c >= 4 && c < 7);
      chk("bp_x", {o_valid, o_x, o_w}, {1'b1, 8'(c < 4 ? c + 1 : c < 8 ? 5 : c - 2), 8'(c < 4 ? c + 1 : c < 8 ? 5 : c - 2)});
      cyc;
    end
    i_ready = 1;
    exp_win++;
    chk("bp_done", {o_valid, 16'(o_win_cnt)}, {1'b0, 16'(exp_win)});
    // continuous flow: 18-cycle period, no pixel accept during issue
    i_en = 1; i_x_valid = 1; lasts = 0;
    for (c = 0; c < 120 && lasts < 3; c++) begin
      i_x = 8'(c);
      if (o_valid) chk("cont_xr_issue", o_x_ready, 0);
      if (o_first) begin
        firsts.push_back(c);
        if (firsts.size() == 3) i_en = 0;
      end
      if (o_last) lasts++;
      cyc;
    end
    i_x_valid = 0;
    chk("cont_windows", lasts, 3);
    chk("cont_nfirst", firsts.size(), 3);
    if (firsts.size() == 3) begin
      chk("cont_period1", firsts[1] - firsts[0], 18);
      chk("cont_period2", firsts[2] - firsts[1], 18);
    end
    exp_win += 3;
    chk("cont_cnt", {o_busy, 16'(o_win_cnt)}, {1'b0, 16'(exp_win)});
    // ignored writes: out-of-range address in IDLE, tap write during FILL
    wr(12, 19'h00055);
    start_window;
    i_w_wr = 1; i_w_addr = 0; i_w_data = 19'h0007F;
    fill;
    i_w_wr = 0;
    issue_chk("illegal_wr");
    exp_win++;
    // signed bias/weight, truncated tap write, write coincident with enable
    wr(9, 19'h7FFFB);
    wr(0, 19'h7FF80);
    i_w_wr = 1; i_w_addr = 8; i_w_data = 19'h7FFFF; i_en = 1;
    cyc;
    i_w_wr = 0; i_en = 0;
    chk("wr_en_busy", o_busy, 1);
    ew[0] = 8'h80; ew[8] = 8'hFF; eb = 19'h7FFFB;
    fill;
    issue_chk("signed");
    exp_win++;
    chk("signed_cnt", o_win_cnt, 16'(exp_win));
    // reset during issue discards the window and clears the bank
    start_window;
    fill;
    repeat (3) cyc;
    chk("mid_tap3", {o_valid, o_x}, {1'b1, 8'd4});
    #2 i_rst = 1;
    #1 chk("mid_reset", {o_valid, o_x, o_w, o_psum, o_busy, o_x_ready, o_win_cnt}, '0);
    cyc;
    i_rst = 0;
    exp_win = 0;
    for (int k = 0; k < 9; k++) begin
      ew[k] = 0;
      cur_px[k] = 8'(8'h30 + k);
    end
    eb = 0;
    start_window;
    fill;
    issue_chk("post_reset");
    exp_win++;
    // randomized run against the scoreboard
    for (int a = 0; a < 10; a++) begin
      logic [18:0] d;
      d = 19'($urandom);
      wr(4'(a), d);
      if (a < 9) m_w[a] = d[7:0];
      else m_b = d;
    end
    i_en = 1;
    repeat (400) rstep;
    i_en = 0;
    n = 0;
    while (o_busy && n < 300) begin
      rstep;
      n++;
    end
    i_ready = 1; i_x_valid = 0;
    chk("rand_drain_busy", o_busy, 0);
    chk("rand_sb_empty", sb.size(), 0);
    chk("rand_pend_empty", pend.size(), 0);
    exp_win += popped / 9;
    chk("rand_win_cnt", o_win_cnt, 16'(exp_win));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
